// File: rtl/qq_arbiter.sv
// Purpose: round-robin arbiter sharing one QuickQ priority queue among N requesters.
// Latency: strobe 1 cycle after the ARB sample; done 2 cycles after it on reject, else 1 cycle after q_rdy_i returns.
// Backpressure: holds in ARB until the queue is ready; the winner keeps its grant until its done pulse.
module qq_arbiter #(
    parameter int W  = 32,   // key width (upper W bits of an entry)
    parameter int VW = 32,   // value width (lower VW bits of an entry)
    parameter int N  = 4     // number of requesters, N >= 2
) (
    input  logic                        clk,
    input  logic                        rst,
    // requester side
    input  logic [N-1:0]                req_i,
    input  logic [N-1:0][1:0]           op_i,
    input  logic [N-1:0][W+VW-1:0]      data_i,
    output logic [N-1:0]                gnt_o,
    output logic [N-1:0]                done_o,
    output logic [N-1:0]                err_o,
    output logic [W+VW-1:0]             data_o,
    // queue side
    input  logic                        q_rdy_i,
    input  logic                        q_full_i,
    input  logic                        q_empty_i,
    input  logic [W+VW-1:0]             q_data_i,
    output logic                        q_enq_o,
    output logic                        q_deq_o,
    output logic                        q_repl_o,
    output logic [W+VW-1:0]             q_data_o
);

    localparam int NW  = $clog2(N);
    localparam int KVW = W + VW;

    localparam logic [1:0] OP_ENQ  = 2'b00;
    localparam logic [1:0] OP_DEQ  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NW-1:0]   r_win;
    logic [NW-1:0]   r_rr_ptr;
    logic [KVW-1:0]  r_data;
    logic [KVW-1:0]  r_data_o;
    logic            r_err;
    logic            r_enq;
    logic            r_deq;
    logic            r_repl;

    logic [NW-1:0]   w_win;
    logic [1:0]      w_op;
    logic            w_accept;
    logic            w_reject;

    // Index wrap for the round-robin search; N need not be a power of two.
    function automatic logic [NW-1:0] f_wrap(input int v);
        if (v >= N) begin
            return NW'(v - N);
        end
        return NW'(v);
    endfunction

    // Winner search: first set request at or above rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        w_win = r_rr_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_win = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    // A command leaves ARB only with a ready queue and at least one request.
    assign w_accept = (r_state == S_ARB) && q_rdy_i && (|req_i);
    assign w_op     = op_i[w_win];

    // Reject decision. The queue is idle and unstrobed from this cycle until the
    // end of ISSUE, so its flags seen here are exactly the flags ISSUE would see;
    // deciding now lets the strobes come straight out of flops.
    assign w_reject = (w_op == OP_ILL)
                   || ((w_op == OP_ENQ) && q_full_i)
                   || (((w_op == OP_DEQ) || (w_op == OP_REPL)) && q_empty_i);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-requester output decode, all from registered state.
    always_comb begin
        w_state_nxt = r_state;
        gnt_o       = '0;
        done_o      = '0;
        err_o       = '0;
        case (r_state)
            S_ARB: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gnt_o[r_win] = 1'b1;
                w_state_nxt  = r_err ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                gnt_o[r_win] = 1'b1;
                if (q_rdy_i) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                gnt_o[r_win]  = 1'b1;
                done_o[r_win] = 1'b1;
                err_o[r_win]  = r_err;
                w_state_nxt   = S_ARB;
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase
    end

    // Command strobes: set on acceptance, so they are high only during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enq  <= 1'b0;
            r_deq  <= 1'b0;
            r_repl <= 1'b0;
        end else begin
            r_enq  <= w_accept && !w_reject && (w_op == OP_ENQ);
            r_deq  <= w_accept && !w_reject && (w_op == OP_DEQ);
            r_repl <= w_accept && !w_reject && (w_op == OP_REPL);
        end
    end

    // Latch the winner, its entry and error flag on acceptance; free them in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win    <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_win  <= w_win;
                r_data <= data_i[w_win];
                r_err  <= w_reject;
            end
            if (r_state == S_RESP) begin
                r_rr_ptr <= (r_win == NW'(N - 1)) ? '0 : r_win + 1'b1;
                r_err    <= 1'b0;
            end
        end
    end

    // Old head capture: the deq/repl strobe cycle still shows the pre-command head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_o <= '0;
        end else if (r_deq || r_repl) begin
            r_data_o <= q_data_i;
        end
    end

    assign q_enq_o  = r_enq;
    assign q_deq_o  = r_deq;
    assign q_repl_o = r_repl;
    assign q_data_o = r_data;
    assign data_o   = r_data_o;

endmodule

// File: doc/qq_arbiter.md
# qq_arbiter

Round-robin arbiter that shares one QuickQ priority-queue instance among N requesters. Each requester presents one command (enqueue, dequeue, replace) with a key/value, and holds it until a completion pulse. The arbiter issues the command to the queue only while the queue is ready, waits for the queue to finish, and returns the old head entry for dequeue/replace. Commands that would underflow or overflow the queue are rejected without reaching it. Sits between the client ports and the QuickQ top.

## Interface
- `W`, 32: key width; must match the queue's `kv_t` key width.
- `N`, 4: number of requesters, N ≥ 2.
- `NW`, localparam `$clog2(N)`: winner-index width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; shared with the queue.
- `req_i`  in  N  per-requester command request, level.
- `op_i`  in  N×2  per-requester opcode: 00 enq, 01 deq, 10 repl, 11 illegal.
- `data_i`  in  N×`kv_t`  per-requester enq/repl entry.
- `gnt_o`  out  N  one-hot, winner owns the queue.
- `done_o`  out  N  one-cycle completion pulse to the winner.
- `err_o`  out  N  one-cycle reject pulse; coincident with `done_o`.
- `data_o`  out  `kv_t`  head entry returned for deq/repl; valid with `done_o`.
- `q_rdy_i`  in  1  queue idle/ready.
- `q_full_i`, `q_empty_i`  in  1 each  queue full/empty flags.
- `q_data_i`  in  `kv_t`  queue head entry (minimum key).
- `q_enq_o`, `q_deq_o`, `q_repl_o`  out  1 each  one-cycle command strobes to the queue.
- `q_data_o`  out  `kv_t`  entry for enq/repl.

## Operation
- State machine: ARB, ISSUE, WAIT, RESP.
- **ARB**
  - The arbiter leaves ARB only when `q_rdy_i` is 1 and `req_i` is nonzero.
  - Winner: the first set `req_i` bit, searching upward from `rr_ptr` with wrap-around.
  - Latch the winner index, `op_i[win]` and `data_i[win]` into registers. Go to ISSUE.
- **ISSUE**
  - `gnt_o[win]` is 1.
  - A command is rejected when any of these holds:
    - op=11;
    - op=00 with `q_full_i`=1;
    - op=01 or op=10 with `q_empty_i`=1.
  - Rejected: no strobe is issued; set the error flag; go to RESP.
  - Otherwise:
    - Pulse the matching `q_*_o` strobe for exactly one cycle, with `q_data_o` = latched data.
    - For deq/repl, capture `q_data_i` into the `data_o` register.
    - Go to WAIT.
- **WAIT**
  - `gnt_o[win]` stays 1.
  - Stay while `q_rdy_i`=0. When `q_rdy_i`=1, go to RESP.
- **RESP**
  - `gnt_o[win]` is 1; `done_o[win]` pulses; `err_o[win]` pulses if the error flag is set.
  - `rr_ptr` ← (win+1) mod N. Clear the error flag. Go to ARB.
- `data_o` holds its value until the next successful deq/repl capture. For enq, `data_o` is unchanged.
- Requesters not granted see `gnt_o`, `done_o` and `err_o` all 0.
- Requester rule: hold `req_i`, `op_i` and `data_i` until `done_o`. The values are sampled only in the ARB cycle. A request still asserted in the cycle after `done_o` is treated as a new command.
- Only this block drives the queue command strobes, so at most one strobe is high in any cycle.

## Timing
- Reset values:
  - state = ARB, `rr_ptr` = 0, error flag = 0;
  - `gnt_o`, `done_o`, `err_o` = 0;
  - all `q_*_o` strobes = 0;
  - `q_data_o` = 0, `data_o` = 0.
- All outputs are registered or decoded from the state register only; none is combinational from inputs.
- Latencies, with ARB sample = cycle 0:
  - Strobe in cycle 1.
  - The queue drops `q_rdy_i` in cycle 2. WAIT therefore lasts at least one cycle.
  - `done_o` in cycle ≥ 3 (cycle 3 + queue busy cycles).
  - Rejected command: `done_o`/`err_o` in cycle 2.
- `q_rdy_i` is 1 in ISSUE by construction (the queue is idle and unstrobed). No re-check is done.
- Back-to-back: after RESP the next grant can be sampled in the following cycle, giving a minimum of 1 idle cycle between grants.
- The queue runs its own init after `rst` with `q_rdy_i`=0. The arbiter stays in ARB, issuing nothing, until `q_rdy_i` rises.
- Reset mid-operation (ISSUE, WAIT or RESP): return to ARB the next cycle. No `done_o` is produced for the aborted command, and requesters must reissue.
- Full/empty flags are sampled in ISSUE, after the previous command has completed, so they are current.

## Test plan
- **Reset then enq:** hold `q_rdy_i`=0 for 5 cycles after `rst`, with `req_i`=0001, op=00, key=0x10.
  - No strobe while `q_rdy_i`=0.
  - After `q_rdy_i` rises: `q_enq_o` pulses once with key 0x10, `gnt_o`=0001.
  - `done_o[0]` one cycle after the queue model's `q_rdy_i` returns high.
- **Round robin:** `rr_ptr`=0, `req_i`=1010 held.
  - First grant goes to requester 1, then requester 3, then requester 1.
  - `gnt_o` is always one-hot.
- **Dequeue value:** queue holds keys 0x05 and 0x09; requester 2 issues deq.
  - `q_deq_o` pulses once; `data_o` key = 0x05 at `done_o[2]`.
  - Next deq returns 0x09.
- **Empty reject:** `q_empty_i`=1; requester 0 issues deq.
  - No `q_deq_o`; `done_o[0]` and `err_o[0]` in cycle 2; `data_o` unchanged.
- **Full reject and illegal op:** `q_full_i`=1, requester 1 enq → no `q_enq_o`, `err_o[1]`=1. Then op=11 → `err_o` pulse, no strobe.
- **Mid-operation reset:** assert `rst` during WAIT.
  - Next cycle: all outputs 0, state ARB, `rr_ptr`=0.
  - No `done_o` for the aborted command.
